// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: md_op encodings and default latencies.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: latches operands, counts down a fixed latency,
// then commits the combinational product/quotient into the HI/LO registers.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W = $clog2(MAX_LAT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   md_op_e           op_q, op_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, b_div_s, b_div_u;
   logic [31:0] uq_mag, ur_mag, quo_s, rem_s, quo_u, rem_u;

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
   assign a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
   assign b_mag   = b_q[31] ? (32'd0 - b_q) : b_q;
   assign b_div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign b_div_u = (b_q == 32'd0) ? 32'd1 : b_q;
   assign uq_mag  = a_mag / b_div_s;
   assign ur_mag  = a_mag % b_div_s;
   assign quo_s   = (a_q[31] ^ b_q[31]) ? (32'd0 - uq_mag) : uq_mag;
   assign rem_s   = a_q[31] ? (32'd0 - ur_mag) : ur_mag;
   assign quo_u   = a_q / b_div_u;
   assign rem_u   = a_q % b_div_u;

   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            case (op_q)
               MD_MULT:  {hi_d, lo_d} = prod_s;
               MD_MULTU: {hi_d, lo_d} = prod_u;
               MD_DIV: if (b_q != 32'd0) begin
                  lo_d = quo_s;
                  hi_d = rem_s;
               end
               MD_DIVU: if (b_q != 32'd0) begin
                  lo_d = quo_u;
                  hi_d = rem_u;
               end
               default: ;
            endcase
         end
      end else if (start) begin
         case (md_op)
            MD_MULT, MD_MULTU: begin
               a_d   = A;
               b_d   = B;
               op_d  = md_op_e'(md_op);
               cnt_d = CNT_W'(MULT_LAT);
            end
            MD_DIV, MD_DIVU: begin
               a_d   = A;
               b_d   = B;
               op_d  = md_op_e'(md_op);
               cnt_d = CNT_W'(DIV_LAT);
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= MD_NONE;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   assign busy = (cnt_q != '0);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

   localparam int MLAT = 5;
   localparam int DLAT = 10;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   logic [31:0] hi_m, lo_m;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of an op, computed with 64-bit arithmetic.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin sp = sa * sb; hi_m = sp[63:32]; lo_m = sp[31:0]; end
         3'd2: begin up = {32'd0, a} * {32'd0, b}; hi_m = up[63:32]; lo_m = up[31:0]; end
         3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo_m = sq[31:0]; hi_m = sr[31:0]; end
         3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
         3'd5: hi_m = a;
         3'd6: lo_m = a;
         default: ;
      endcase
   endtask

   function automatic int lat_of(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return MLAT;
      if (op == 3'd3 || op == 3'd4) return DLAT;
      return 0;
   endfunction

   // Issue one op for a single cycle and check busy window and the committed result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          lat;
      logic [31:0] hi_old, lo_old;
      lat    = lat_of(op);
      hi_old = hi_m;
      lo_old = lo_m;
      start = 1'b1; md_op = op; A = a; B = b;
      tick();
      start = 1'b0; A = $urandom; B = $urandom; md_op = 3'($urandom_range(0, 7));
      for (int i = 0; i < lat; i++) begin
         chk({tag, " busy"}, {31'd0, busy}, 32'd1);
         if (i == lat - 1) begin
            chk({tag, " hold HI"}, HI, hi_old);
            chk({tag, " hold LO"}, LO, lo_old);
         end
         tick();
      end
      model(op, a, b);
      chk({tag, " idle"}, {31'd0, busy}, 32'd0);
      chk({tag, " HI"}, HI, hi_m);
      chk({tag, " LO"}, LO, lo_m);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
      hi_m = '0; lo_m = '0;
      tick(); tick();
      reset = 1'b0;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset HI", HI, 32'd0);
      chk("reset LO", LO, 32'd0);

      run_op("mult -2*3", 3'd1, 32'hFFFF_FFFE, 32'd3);
      chk("mult -2*3 HI const", HI, 32'hFFFF_FFFF);
      chk("mult -2*3 LO const", LO, 32'hFFFF_FFFA);
      run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
      chk("multu HI const", HI, 32'h0000_0001);
      chk("multu LO const", LO, 32'hFFFF_FFFE);
      run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div LO const", LO, 32'hFFFF_FFFD);
      chk("div HI const", HI, 32'hFFFF_FFFF);
      run_op("divu 7/0", 3'd4, 32'd7, 32'd0);
      chk("divu/0 LO const", LO, 32'hFFFF_FFFD);
      run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div ovf LO const", LO, 32'h8000_0000);
      chk("div ovf HI const", HI, 32'd0);
      run_op("mthi", 3'd5, 32'h1234_5678, 32'd0);
      run_op("mtlo", 3'd6, 32'h0000_0009, 32'd0);
      chk("mthi HI const", HI, 32'h1234_5678);
      chk("mtlo LO const", LO, 32'h0000_0009);
      run_op("none", 3'd0, 32'hDEAD_BEEF, 32'd1);
      run_op("undef", 3'd7, 32'hDEAD_BEEF, 32'd1);

      // Reset in the fourth busy cycle of a divide.
      run_op("pre-rst mult", 3'd1, 32'h0001_0003, 32'h0002_0005);
      start = 1'b1; md_op = 3'd4; A = 32'd100; B = 32'd7;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("rst c4 busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hi_m = '0; lo_m = '0;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst HI", HI, 32'd0);
      chk("rst LO", LO, 32'd0);
      for (int i = 0; i < DLAT + 2; i++) tick();
      chk("rst no late HI", HI, 32'd0);
      chk("rst no late LO", LO, 32'd0);
      chk("rst no late busy", {31'd0, busy}, 32'd0);

      // Start while busy must be ignored.
      start = 1'b1; md_op = 3'd1; A = 32'hFFFF_FFF0; B = 32'd16;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; md_op = 3'd4; A = 32'd1000; B = 32'd3;
      tick();
      start = 1'b0; md_op = 3'd0;
      tick(); tick();
      chk("ign busy c5", {31'd0, busy}, 32'd1);
      tick();
      model(3'd1, 32'hFFFF_FFF0, 32'd16);
      chk("ign busy end", {31'd0, busy}, 32'd0);
      chk("ign HI", HI, hi_m);
      chk("ign LO", LO, lo_m);
      tick();
      chk("ign no divu", {31'd0, busy}, 32'd0);
      chk("ign LO stable", LO, lo_m);

      for (int n = 0; n < 60; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 5) == 0) rb = -rb;
         run_op("rand", rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
